// File: rtl/dbg_probe_mux.sv
// Debug probe selector: picks one of NCH probe channels (manual select or auto-scan) into a registered OW-bit display window.
// Latency: one cycle from sel/ch_bus/scan pointer to out/out_ch; trigger compare is combinational, its effect registered.
// Backpressure: none; free-running sampler. DBG_PROBE_SNAP_EN builds the snapshot bank with the LIVE/ARMED/HOLD FSM.
// The snapshot-drop pulse is named rel because "release" is a reserved word in SystemVerilog.
module dbg_probe_mux #(
    parameter int NCH      = 16,
    parameter int DW       = 32,
    parameter int OW       = 13,
    parameter int SCAN_DIV = 4,
    parameter int TRIG_CH  = 0,
    parameter int SELW     = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*DW-1:0] ch_bus,
    input  logic [SELW-1:0]   sel,
    input  logic              scan_en,
    input  logic              arm,
    input  logic              snap,
    input  logic              rel,
    input  logic [DW-1:0]     trig_val,
    output logic [OW-1:0]     out,
    output logic [SELW-1:0]   out_ch,
    output logic              armed,
    output logic              held
);

    // A divider width of at least one bit keeps SCAN_DIV = 1 legal.
    localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIVW-1:0] div_cnt;
    logic [SELW-1:0] scan_ptr;
    logic [SELW-1:0] ptr;
    logic [DW-1:0]   view [NCH];
    logic [DW-1:0]   src;

    // Scan divider and pointer; both parked at 0 while scan is off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            scan_ptr <= '0;
        end else if (!scan_en) begin
            div_cnt  <= '0;
            scan_ptr <= '0;
        end else if (div_cnt == DIVW'(SCAN_DIV - 1)) begin
            div_cnt  <= '0;
            scan_ptr <= (scan_ptr == SELW'(NCH - 1)) ? '0 : scan_ptr + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign ptr = scan_en ? scan_ptr : sel;

`ifdef DBG_PROBE_SNAP_EN
    typedef enum logic [1:0] {S_LIVE, S_ARMED, S_HOLD} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          trig_hit;
    logic          capture;
    logic [DW-1:0] bank [NCH];

    assign trig_hit = (ch_bus[TRIG_CH*DW +: DW] == trig_val);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LIVE;
        else        state <= state_nxt;
    end

    // Next state: capture beats release, release beats arm; HOLD ignores arm/snap.
    always_comb begin
        state_nxt = state;
        case (state)
            S_LIVE: begin
                if (snap)     state_nxt = S_HOLD;
                else if (arm) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (snap || trig_hit) state_nxt = S_HOLD;
                else if (rel)         state_nxt = S_LIVE;
            end
            S_HOLD: begin
                if (rel) state_nxt = S_LIVE;
            end
            default: state_nxt = S_LIVE;
        endcase
    end

    // FSM outputs: status flags and the capture strobe for the bank.
    always_comb begin
        armed   = (state == S_ARMED);
        held    = (state == S_HOLD);
        capture = ((state == S_LIVE) && snap) ||
                  ((state == S_ARMED) && (snap || trig_hit));
    end

    // Snapshot bank freezes every channel on the same edge the FSM enters HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) bank[k] <= '0;
        end else if (capture) begin
            for (int k = 0; k < NCH; k++) bank[k] <= ch_bus[k*DW +: DW];
        end
    end

    // Channel view: frozen bank while holding, live probes otherwise.
    always_comb begin
        for (int k = 0; k < NCH; k++) view[k] = held ? bank[k] : ch_bus[k*DW +: DW];
    end
`else
    // Snapshot controls have no function in this build.
    logic unused_snap_ctrl;
    assign unused_snap_ctrl = ^{arm, snap, rel, trig_val};
    assign armed = 1'b0;
    assign held  = 1'b0;

    // Channel view is always the live probe set.
    always_comb begin
        for (int k = 0; k < NCH; k++) view[k] = ch_bus[k*DW +: DW];
    end
`endif

    // Pointer decode; an index past NCH-1 selects zero.
    always_comb begin
        src = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ptr == SELW'(k)) src = view[k];
        end
    end

    // Registered display window: plain truncation to the low OW bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out    <= '0;
            out_ch <= '0;
        end else begin
            out    <= src[OW-1:0];
            out_ch <= ptr;
        end
    end

endmodule

// File: tb/tb_dbg_probe_mux.sv
// Directed bench for dbg_probe_mux: a 16-channel instance (SCAN_DIV=4) and a 12-channel instance (SCAN_DIV=1).
// Expected values are hand-derived from the probe patterns loaded below.
// Snapshot checks follow whichever build of the design is compiled.
module tb_dbg_probe_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 16-channel instance signals
    logic [16*32-1:0] bus16;
    logic [31:0]      ch16 [16];
    logic [3:0]       sel16;
    logic             scan16, arm16, snap16, rel16;
    logic [31:0]      trig16;
    logic [12:0]      out16;
    logic [3:0]       och16;
    logic             armed16, held16;

    // 12-channel instance signals
    logic [12*32-1:0] bus12;
    logic [31:0]      ch12 [12];
    logic [3:0]       sel12;
    logic             scan12, arm12, snap12, rel12;
    logic [31:0]      trig12;
    logic [12:0]      out12;
    logic [3:0]       och12;
    logic             armed12, held12;

    logic [31:0] bank_m [16];
    int n_assert = 0;
    int n_fail   = 0;

    always_comb begin
        bus16 = '0;
        for (int k = 0; k < 16; k++) bus16[k*32 +: 32] = ch16[k];
    end

    always_comb begin
        bus12 = '0;
        for (int k = 0; k < 12; k++) bus12[k*32 +: 32] = ch12[k];
    end

    dbg_probe_mux #(.NCH(16), .DW(32), .OW(13), .SCAN_DIV(4), .TRIG_CH(0)) u16 (
        .clk(clk), .rst_n(rst_n), .ch_bus(bus16), .sel(sel16), .scan_en(scan16),
        .arm(arm16), .snap(snap16), .rel(rel16), .trig_val(trig16),
        .out(out16), .out_ch(och16), .armed(armed16), .held(held16)
    );

    dbg_probe_mux #(.NCH(12), .DW(32), .OW(13), .SCAN_DIV(1), .TRIG_CH(0)) u12 (
        .clk(clk), .rst_n(rst_n), .ch_bus(bus12), .sel(sel12), .scan_en(scan12),
        .arm(arm12), .snap(snap12), .rel(rel12), .trig_val(trig12),
        .out(out12), .out_ch(och12), .armed(armed12), .held(held12)
    );

    function automatic logic [31:0] lo13(input logic [31:0] v);
        return {19'd0, v[12:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Four distinct probe patterns; upper bits set to exercise truncation.
    task automatic set_pat(input int p);
        for (int k = 0; k < 16; k++) begin
            case (p)
                0:       ch16[k] = 32'hF000_0000 | (k * 32'h111 + 32'h3);
                1:       ch16[k] = 32'h0BAD_0000 + k * 32'h205 + 32'h40;
                2:       ch16[k] = 32'h1234_0000 + k * 32'h9 + 32'h7;
                default: ch16[k] = ~(32'h1234_0000 + k * 32'h9 + 32'h7);
            endcase
        end
        if (p == 0) ch16[2] = 32'h0000_1A2B;
    endtask

    initial begin
        rst_n  = 1'b0;
        sel16  = 4'd2; scan16 = 1'b0; arm16 = 1'b0; snap16 = 1'b0; rel16 = 1'b0; trig16 = 32'd0;
        sel12  = 4'd0; scan12 = 1'b0; arm12 = 1'b0; snap12 = 1'b0; rel12 = 1'b0; trig12 = 32'd0;
        set_pat(0);
        for (int k = 0; k < 12; k++) ch12[k] = 32'h5550_0000 + k * 32'h123 + 32'h1;

        // Reset state
        tick(); tick();
        chk("rst_out", out16, 32'd0);
        chk("rst_out_ch", och16, 32'd0);
        chk("rst_armed", armed16, 32'd0);
        chk("rst_held", held16, 32'd0);
        chk("rst_out12", out12, 32'd0);
        chk("rst_armed12", armed12, 32'd0);
        chk("rst_held12", held12, 32'd0);

        // First registered value after reset release
        rst_n = 1'b1;
        tick();
        chk("post_rst_out", out16, 32'h1A2B);
        chk("post_rst_out_ch", och16, 32'd2);

        sel16 = 4'd5;
        tick();
        chk("sel5_out", out16, lo13(ch16[5]));
        chk("sel5_ch", och16, 32'd5);

        // Auto-scan: each channel shown 4 cycles, wrap 15 -> 0
        scan16 = 1'b1;
        for (int i = 1; i <= 68; i++) begin
            tick();
            chk("scan_ch", och16, ((i - 1) / 4) % 16);
            chk("scan_out", out16, lo13(ch16[((i - 1) / 4) % 16]));
        end
        scan16 = 1'b0;
        sel16  = 4'd7;
        tick();
        chk("unscan_ch", och16, 32'd7);
        chk("unscan_out", out16, lo13(ch16[7]));

`ifdef DBG_PROBE_SNAP_EN
        // Armed trigger on ch0 == 0x104
        sel16  = 4'd0;
        trig16 = 32'h104;
        arm16  = 1'b1;
        tick();
        arm16 = 1'b0;
        chk("arm_armed", armed16, 32'd1);
        chk("arm_held", held16, 32'd0);
        ch16[0] = 32'h100;
        tick();
        chk("pre_trig_armed", armed16, 32'd1);
        chk("pre_trig_held", held16, 32'd0);
        chk("pre_trig_out", out16, 32'h100);
        ch16[0] = 32'h104;
        tick();
        for (int k = 0; k < 16; k++) bank_m[k] = ch16[k];
        chk("trig_held", held16, 32'd1);
        chk("trig_armed", armed16, 32'd0);
        ch16[0] = 32'h108;
        tick();
        chk("hold_ch0", out16, 32'h104);
        set_pat(1);
        for (int k = 0; k < 16; k++) begin
            sel16 = k[3:0];
            tick();
            chk("hold_browse_out", out16, lo13(bank_m[k]));
            chk("hold_browse_ch", och16, k);
        end

        // Snap while holding does not recapture
        snap16 = 1'b1;
        tick();
        snap16 = 1'b0;
        chk("hold_snap_held", held16, 32'd1);
        sel16 = 4'd3;
        tick();
        chk("no_recapture", out16, lo13(bank_m[3]));

        // Release: live data one edge later
        rel16 = 1'b1;
        tick();
        rel16 = 1'b0;
        chk("rel_held", held16, 32'd0);
        chk("rel_edge_out", out16, lo13(bank_m[3]));
        tick();
        chk("rel_live_out", out16, lo13(ch16[3]));

        // Release from ARMED
        arm16 = 1'b1;
        tick();
        arm16 = 1'b0;
        chk("rearm_armed", armed16, 32'd1);
        rel16 = 1'b1;
        tick();
        rel16 = 1'b0;
        chk("armed_rel_armed", armed16, 32'd0);
        chk("armed_rel_held", held16, 32'd0);

        // Snap and release together in ARMED: capture wins
        arm16 = 1'b1;
        tick();
        arm16 = 1'b0;
        set_pat(2);
        snap16 = 1'b1;
        rel16  = 1'b1;
        tick();
        snap16 = 1'b0;
        rel16  = 1'b0;
        for (int k = 0; k < 16; k++) bank_m[k] = ch16[k];
        chk("snap_rel_held", held16, 32'd1);
        chk("snap_rel_armed", armed16, 32'd0);
        set_pat(3);
        sel16 = 4'd4;
        tick();
        chk("snap_rel_out", out16, lo13(bank_m[4]));

        // Asynchronous reset in the middle of HOLD
        rst_n = 1'b0;
        #1;
        chk("async_rst_held", held16, 32'd0);
        chk("async_rst_out", out16, 32'd0);
        chk("async_rst_ch", och16, 32'd0);
        rst_n = 1'b1;
`else
        // Snapshot controls have no effect
        sel16  = 4'd0;
        trig16 = ch16[0];
        arm16  = 1'b1;
        snap16 = 1'b1;
        tick();
        arm16  = 1'b0;
        snap16 = 1'b0;
        chk("nosnap_armed", armed16, 32'd0);
        chk("nosnap_held", held16, 32'd0);
        chk("nosnap_out", out16, lo13(ch16[0]));
        ch16[0] = 32'h0000_0ABC;
        tick();
        chk("nosnap_live", out16, 32'h0ABC);
        chk("nosnap_held2", held16, 32'd0);
        rel16 = 1'b1;
        sel16 = 4'd9;
        tick();
        rel16 = 1'b0;
        chk("nosnap_rel_out", out16, lo13(ch16[9]));

        // Asynchronous reset mid-operation
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", out16, 32'd0);
        chk("async_rst_ch", och16, 32'd0);
        rst_n = 1'b1;
`endif

        // Non-power-of-two channel count: out-of-range select
        sel12 = 4'd13;
        tick();
        chk("oor_out", out12, 32'd0);
        chk("oor_ch", och12, 32'd13);
        sel12 = 4'd11;
        tick();
        chk("ch11_out", out12, lo13(ch12[11]));

        // SCAN_DIV = 1 advances every cycle, wrap 11 -> 0
        scan12 = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            chk("scan12_ch", och12, (i - 1) % 12);
        end
        scan12 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
